// File: rtl/frame_buffer_start_ctrl_pkg.sv
// Shared constants and FSM state encoding for the frame buffer start/stop controller.
package frame_buffer_start_ctrl_pkg;

    localparam int LEADER_BYTES_DEF        = 52;
    localparam int TRAILER_BYTES_DEF       = 32;
    localparam int CHUNK_TRAILER_BYTES_DEF = 36;
    localparam int FRAME_CNT_WIDTH         = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_LOW   = 2'd1,
        ST_WAIT_FRAME = 2'd2,
        ST_IN_FRAME   = 2'd3
    } state_t;

endpackage

// File: rtl/frame_buffer_start_ctrl_if.sv
// Capture-side bundle between the sensor front end (master) and the start controller (slave).
interface frame_buffer_start_ctrl_if #(
    parameter int PTR_WIDTH        = 2,
    parameter int FRAME_SIZE_WIDTH = 22
);
    logic                        i_fval;
    logic                        i_start_full_frame;
    logic                        i_start_quick;
    logic                        i_chunk_mode_active;
    logic [PTR_WIDTH-1:0]        iv_frame_depth;
    logic [FRAME_SIZE_WIDTH-1:0] iv_frame_size_byte;

    logic                        o_fval;
    logic                        o_frame_start;
    logic                        o_frame_done;
    logic                        o_flush;
    logic                        o_size_err;
    logic [PTR_WIDTH-1:0]        ov_frame_depth;
    logic [FRAME_SIZE_WIDTH-1:0] ov_frame_size;
    logic [15:0]                 ov_frame_cnt;

    modport master (
        output i_fval, i_start_full_frame, i_start_quick, i_chunk_mode_active,
               iv_frame_depth, iv_frame_size_byte,
        input  o_fval, o_frame_start, o_frame_done, o_flush, o_size_err,
               ov_frame_depth, ov_frame_size, ov_frame_cnt
    );

    modport slave (
        input  i_fval, i_start_full_frame, i_start_quick, i_chunk_mode_active,
               iv_frame_depth, iv_frame_size_byte,
        output o_fval, o_frame_start, o_frame_done, o_flush, o_size_err,
               ov_frame_depth, ov_frame_size, ov_frame_cnt
    );
endinterface

// File: rtl/frame_buffer_start_ctrl_fval_edge_detect.sv
// One-cycle delayed copy of frame valid with rise/fall strobes against the live input.
module fval_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic fval,
    output logic rise,
    output logic fall
);
    logic fval_d_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fval_d_reg <= 1'b0;
        end else begin
            fval_d_reg <= fval;
        end
    end

    assign rise = fval & ~fval_d_reg;
    assign fall = ~fval & fval_d_reg;
endmodule

// File: rtl/frame_buffer_start_ctrl.sv
// Gates sensor frame valid so the buffer sees whole frames only; latches depth/size per frame.
// Build option: CHUNK_MODE_EN lets i_chunk_mode_active pick the longer chunk trailer.
module frame_buffer_start_ctrl
    import frame_buffer_start_ctrl_pkg::*;
#(
    parameter int PTR_WIDTH           = 2,
    parameter int FRAME_SIZE_WIDTH    = 22,
    parameter int LEADER_BYTES        = LEADER_BYTES_DEF,
    parameter int TRAILER_BYTES       = TRAILER_BYTES_DEF,
    parameter int CHUNK_TRAILER_BYTES = CHUNK_TRAILER_BYTES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    frame_buffer_start_ctrl_if.slave bus
);

`ifdef CHUNK_MODE_EN
    localparam bit CHUNK_EN = 1'b1;
`else
    localparam bit CHUNK_EN = 1'b0;
`endif

    localparam logic [FRAME_SIZE_WIDTH-1:0] SUB_PLAIN =
        FRAME_SIZE_WIDTH'(LEADER_BYTES + TRAILER_BYTES);
    localparam logic [FRAME_SIZE_WIDTH-1:0] SUB_CHUNK =
        FRAME_SIZE_WIDTH'(LEADER_BYTES + CHUNK_TRAILER_BYTES);

    state_t                        state_reg;
    logic                          fval_out_reg;
    logic                          start_reg;
    logic                          done_reg;
    logic                          flush_reg;
    logic                          size_err_reg;
    logic [PTR_WIDTH-1:0]          depth_reg;
    logic [FRAME_SIZE_WIDTH-1:0]   size_reg;
    logic [FRAME_CNT_WIDTH-1:0]    cnt_reg;

    logic                          enable;
    logic                          rise;
    logic                          fall;
    logic [FRAME_SIZE_WIDTH-1:0]   sub_bytes;
    logic                          size_short;
    logic [FRAME_SIZE_WIDTH-1:0]   size_next;
    logic [PTR_WIDTH-1:0]          depth_next;

    fval_edge_detect u_fval_edge (
        .clk   (clk),
        .reset (reset),
        .fval  (bus.i_fval),
        .rise  (rise),
        .fall  (fall)
    );

    assign enable = bus.i_start_full_frame & bus.i_start_quick;

    // Values that would be captured if a frame starts this cycle.
    always_comb begin
        sub_bytes  = (CHUNK_EN && bus.i_chunk_mode_active) ? SUB_CHUNK : SUB_PLAIN;
        size_short = bus.iv_frame_size_byte < sub_bytes;
        size_next  = size_short ? '0 : bus.iv_frame_size_byte - sub_bytes;
        depth_next = (bus.iv_frame_depth == '0) ? PTR_WIDTH'(1) : bus.iv_frame_depth;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            fval_out_reg <= 1'b0;
            start_reg    <= 1'b0;
            done_reg     <= 1'b0;
            flush_reg    <= 1'b0;
            size_err_reg <= 1'b0;
            depth_reg    <= PTR_WIDTH'(1);
            size_reg     <= '0;
            cnt_reg      <= '0;
        end else begin
            start_reg    <= 1'b0;
            done_reg     <= 1'b0;
            flush_reg    <= 1'b0;
            fval_out_reg <= 1'b0;
            case (state_reg)
                // A frame already in progress when enabled must drain before we arm.
                ST_IDLE: begin
                    if (enable) begin
                        state_reg <= bus.i_fval ? ST_WAIT_LOW : ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!enable) begin
                        state_reg <= ST_IDLE;
                    end else if (!bus.i_fval) begin
                        state_reg <= ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (!enable) begin
                        state_reg <= ST_IDLE;
                    end else if (rise) begin
                        state_reg    <= ST_IN_FRAME;
                        fval_out_reg <= 1'b1;
                        start_reg    <= 1'b1;
                        depth_reg    <= depth_next;
                        size_reg     <= size_next;
                        size_err_reg <= size_short;
                    end
                end
                // End of frame wins over a simultaneous quick stop.
                ST_IN_FRAME: begin
                    if (fall) begin
                        done_reg  <= 1'b1;
                        cnt_reg   <= cnt_reg + FRAME_CNT_WIDTH'(1);
                        state_reg <= enable ? ST_WAIT_FRAME : ST_IDLE;
                    end else if (!bus.i_start_quick) begin
                        flush_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        fval_out_reg <= bus.i_fval;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_fval         = fval_out_reg;
    assign bus.o_frame_start  = start_reg;
    assign bus.o_frame_done   = done_reg;
    assign bus.o_flush        = flush_reg;
    assign bus.o_size_err     = size_err_reg;
    assign bus.ov_frame_depth = depth_reg;
    assign bus.ov_frame_size  = size_reg;
    assign bus.ov_frame_cnt   = cnt_reg;

endmodule
